// File: rtl/b_risc_pkg.sv
// Shared b-risc definitions used by the writeback path and the register file.
package b_risc_pkg;

    localparam int REG_W     = 32;
    localparam int REG_COUNT = 32;
    localparam int REG_IDX_W = $clog2(REG_COUNT);

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_MEM  = 2'd2
    } wb_src_t;

endpackage

// File: rtl/wb_arbiter.sv
// Writeback source arbiter: MEM normally wins, ALU is forced through after MAX_WAIT starved cycles.
module wb_arbiter
    import b_risc_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic    clk,
    input  logic    areset,
    input  logic    alu_valid,
    input  logic    mem_valid,
    output wb_src_t grant
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;
    wb_src_t           grant_s;

    // Grant selection; nothing is granted while reset is held so no handshake is lost.
    always_comb begin
        grant_s = WB_NONE;
        if (areset) begin
            grant_s = WB_NONE;
        end else if (alu_valid && (wait_q == WAIT_LIMIT)) begin
            grant_s = WB_ALU;
        end else if (mem_valid) begin
            grant_s = WB_MEM;
        end else if (alu_valid) begin
            grant_s = WB_ALU;
        end else begin
            grant_s = WB_NONE;
        end
    end

    // Starvation counter next value, saturating at the limit.
    always_comb begin
        wait_d = wait_q;
        if (!alu_valid || (grant_s == WB_ALU)) begin
            wait_d = {WAIT_W{1'b0}};
        end else if (wait_q != WAIT_LIMIT) begin
            wait_d = wait_q + {{(WAIT_W-1){1'b0}}, 1'b1};
        end else begin
            wait_d = wait_q;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wait_q <= {WAIT_W{1'b0}};
        end else begin
            wait_q <= wait_d;
        end
    end

    assign grant = grant_s;

endmodule

// File: rtl/reg_writeback.sv
// Register-file writer: arbitrates ALU/load results, drops x0 writes and registers the write port.
module reg_writeback
    import b_risc_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [REG_IDX_W-1:0] alu_reg,
    input  logic [REG_W-1:0]     alu_data,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [REG_IDX_W-1:0] mem_reg,
    input  logic [REG_W-1:0]     mem_data,
    output logic                 wr_en,
    output logic [REG_IDX_W-1:0] wr_reg,
    output logic [REG_W-1:0]     wr_data,
    output logic [31:0]          retire_count
);

    wb_src_t              grant_s;
    logic                 wr_en_q;
    logic                 wr_en_d;
    logic [REG_IDX_W-1:0] wr_reg_q;
    logic [REG_IDX_W-1:0] wr_reg_d;
    logic [REG_W-1:0]     wr_data_q;
    logic [REG_W-1:0]     wr_data_d;
    logic [31:0]          retire_q;
    logic [31:0]          retire_d;

    wb_arbiter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_arbiter (
        .clk       (clk),
        .areset    (areset),
        .alu_valid (alu_valid),
        .mem_valid (mem_valid),
        .grant     (grant_s)
    );

    assign alu_ready = (grant_s == WB_ALU);
    assign mem_ready = (grant_s == WB_MEM);

    // Capture the granted result; index/data track even x0 so the port reflects the last transfer.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_reg_d  = wr_reg_q;
        wr_data_d = wr_data_q;
        case (grant_s)
            WB_ALU: begin
                wr_en_d   = (alu_reg != {REG_IDX_W{1'b0}});
                wr_reg_d  = alu_reg;
                wr_data_d = alu_data;
            end
            WB_MEM: begin
                wr_en_d   = (mem_reg != {REG_IDX_W{1'b0}});
                wr_reg_d  = mem_reg;
                wr_data_d = mem_data;
            end
            default: begin
                wr_en_d   = 1'b0;
                wr_reg_d  = wr_reg_q;
                wr_data_d = wr_data_q;
            end
        endcase
    end

    // Retired-write counter counts cycles where the write port is enabled; wraps naturally.
    always_comb begin
        retire_d = retire_q;
        if (wr_en_q) begin
            retire_d = retire_q + 32'd1;
        end else begin
            retire_d = retire_q;
        end
    end

    // Output and counter registers.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wr_en_q   <= 1'b0;
            wr_reg_q  <= {REG_IDX_W{1'b0}};
            wr_data_q <= {REG_W{1'b0}};
            retire_q  <= 32'd0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
            retire_q  <= retire_d;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_reg       = wr_reg_q;
    assign wr_data      = wr_data_q;
    assign retire_count = retire_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed self-checking bench for reg_writeback with a behavioural register file on the write port.
module tb_reg_writeback;
    import b_risc_pkg::*;

    logic                 clk = 1'b0;
    logic                 areset;
    logic                 alu_valid;
    logic                 alu_ready;
    logic [REG_IDX_W-1:0] alu_reg;
    logic [REG_W-1:0]     alu_data;
    logic                 mem_valid;
    logic                 mem_ready;
    logic [REG_IDX_W-1:0] mem_reg;
    logic [REG_W-1:0]     mem_data;
    logic                 wr_en;
    logic [REG_IDX_W-1:0] wr_reg;
    logic [REG_W-1:0]     wr_data;
    logic [31:0]          retire_count;

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [31:0] exp_retire;
    logic [31:0] regfile [REG_COUNT];
    logic [31:0] vals    [REG_COUNT];

    reg_writeback #(.MAX_WAIT(4)) dut (
        .clk          (clk),
        .areset       (areset),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_reg      (alu_reg),
        .alu_data     (alu_data),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_reg      (mem_reg),
        .mem_data     (mem_data),
        .wr_en        (wr_en),
        .wr_reg       (wr_reg),
        .wr_data      (wr_data),
        .retire_count (retire_count)
    );

    always #5 clk = ~clk;

    // Register file stand-in: commits whatever the DUT enables on its write port.
    always @(posedge clk) begin
        if (wr_en) regfile[wr_reg] <= wr_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        areset = 1'b1; alu_valid = 1'b1; alu_reg = 5'd7; alu_data = 32'hA5A5A5A5;
        mem_valid = 1'b0; mem_reg = 5'd0; mem_data = 32'd0;
        step(); step();
        total_cnt++; if (alu_ready !== 1'b0) $display("FAIL reset_alu_ready got %b want 0", alu_ready); else pass_cnt++;
        total_cnt++; if (mem_ready !== 1'b0) $display("FAIL reset_mem_ready got %b want 0", mem_ready); else pass_cnt++;
        total_cnt++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en got %b want 0", wr_en); else pass_cnt++;
        total_cnt++; if (wr_reg !== 5'd0 || wr_data !== 32'd0) $display("FAIL reset_wr_port got %0d/%h want 0/0", wr_reg, wr_data); else pass_cnt++;
        total_cnt++; if (retire_count !== 32'd0) $display("FAIL reset_retire got %0d want 0", retire_count); else pass_cnt++;
        areset = 1'b0;
        #1;
        total_cnt++; if (alu_ready !== 1'b1) $display("FAIL release_alu_ready got %b want 1", alu_ready); else pass_cnt++;
        step();
        alu_valid = 1'b0;
        total_cnt++; if (wr_en !== 1'b1 || wr_reg !== 5'd7 || wr_data !== 32'hA5A5A5A5)
            $display("FAIL release_write got %b/%0d/%h want 1/7/a5a5a5a5", wr_en, wr_reg, wr_data); else pass_cnt++;
        step();
        total_cnt++; if (retire_count !== 32'd1) $display("FAIL release_retire got %0d want 1", retire_count); else pass_cnt++;
        exp_retire = 32'd1;
    endtask

    task automatic test_mid_reset();
        alu_valid = 1'b1; alu_reg = 5'd9; alu_data = 32'h99;
        step();
        alu_valid = 1'b0;
        areset = 1'b1;
        #1;
        total_cnt++; if (wr_en !== 1'b0 || wr_reg !== 5'd0) $display("FAIL midreset_drop got %b/%0d want 0/0", wr_en, wr_reg); else pass_cnt++;
        total_cnt++; if (retire_count !== 32'd0) $display("FAIL midreset_retire got %0d want 0", retire_count); else pass_cnt++;
        step();
        areset = 1'b0;
        step();
        total_cnt++; if (wr_en !== 1'b0) $display("FAIL midreset_no_replay got %b want 0", wr_en); else pass_cnt++;
        exp_retire = 32'd0;
    endtask

    task automatic test_single_alu();
        alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        total_cnt++; if (alu_ready !== 1'b1 || mem_ready !== 1'b0) $display("FAIL single_ready got %b/%b want 1/0", alu_ready, mem_ready); else pass_cnt++;
        step();
        alu_valid = 1'b0;
        total_cnt++; if (wr_en !== 1'b1 || wr_reg !== 5'd5 || wr_data !== 32'hDEADBEEF)
            $display("FAIL single_write got %b/%0d/%h want 1/5/deadbeef", wr_en, wr_reg, wr_data); else pass_cnt++;
        step();
        exp_retire = exp_retire + 32'd1;
        total_cnt++; if (wr_en !== 1'b0 || wr_reg !== 5'd5 || wr_data !== 32'hDEADBEEF)
            $display("FAIL single_hold got %b/%0d/%h want 0/5/deadbeef", wr_en, wr_reg, wr_data); else pass_cnt++;
        total_cnt++; if (retire_count !== exp_retire) $display("FAIL single_retire got %0d want %0d", retire_count, exp_retire); else pass_cnt++;
    endtask

    task automatic test_priority();
        mem_valid = 1'b1; mem_reg = 5'd3; mem_data = 32'h11;
        alu_valid = 1'b1; alu_reg = 5'd4; alu_data = 32'h22;
        #1;
        total_cnt++; if (mem_ready !== 1'b1 || alu_ready !== 1'b0) $display("FAIL prio_ready got mem=%b alu=%b want 1/0", mem_ready, alu_ready); else pass_cnt++;
        step();
        mem_valid = 1'b0;
        total_cnt++; if (wr_en !== 1'b1 || wr_reg !== 5'd3 || wr_data !== 32'h11)
            $display("FAIL prio_first got %b/%0d/%h want 1/3/11", wr_en, wr_reg, wr_data); else pass_cnt++;
        #1;
        total_cnt++; if (alu_ready !== 1'b1) $display("FAIL prio_alu_next got %b want 1", alu_ready); else pass_cnt++;
        step();
        alu_valid = 1'b0;
        total_cnt++; if (wr_en !== 1'b1 || wr_reg !== 5'd4 || wr_data !== 32'h22)
            $display("FAIL prio_second got %b/%0d/%h want 1/4/22", wr_en, wr_reg, wr_data); else pass_cnt++;
        step();
        exp_retire = exp_retire + 32'd2;
        total_cnt++; if (retire_count !== exp_retire) $display("FAIL prio_retire got %0d want %0d", retire_count, exp_retire); else pass_cnt++;
    endtask

    task automatic test_starvation();
        int m = 0;
        logic exp_alu;
        alu_valid = 1'b1; alu_reg = 5'd20; alu_data = 32'hCAFE;
        mem_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            mem_reg  = 5'(8 + m);
            mem_data = 32'h100 + 32'(m);
            exp_alu  = (i == 4);
            #1;
            total_cnt++; if (alu_ready !== exp_alu || mem_ready !== !exp_alu)
                $display("FAIL starve_ready cycle %0d got alu=%b mem=%b want %b/%b", i, alu_ready, mem_ready, exp_alu, !exp_alu); else pass_cnt++;
            step();
            if (exp_alu) begin
                total_cnt++; if (wr_en !== 1'b1 || wr_reg !== 5'd20 || wr_data !== 32'hCAFE)
                    $display("FAIL starve_alu_write got %b/%0d/%h want 1/20/cafe", wr_en, wr_reg, wr_data); else pass_cnt++;
                alu_valid = 1'b0;
            end else begin
                total_cnt++; if (wr_en !== 1'b1 || wr_reg !== 5'(8 + m) || wr_data !== 32'h100 + 32'(m))
                    $display("FAIL starve_mem_write cycle %0d got %b/%0d/%h want 1/%0d/%h", i, wr_en, wr_reg, wr_data, 8 + m, 32'h100 + 32'(m)); else pass_cnt++;
                m++;
            end
        end
        mem_valid = 1'b0;
        step();
        exp_retire = exp_retire + 32'd10;
        total_cnt++; if (retire_count !== exp_retire) $display("FAIL starve_retire got %0d want %0d", retire_count, exp_retire); else pass_cnt++;
    endtask

    task automatic test_x0();
        alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'h55;
        #1;
        total_cnt++; if (alu_ready !== 1'b1) $display("FAIL x0_ready got %b want 1", alu_ready); else pass_cnt++;
        step();
        alu_valid = 1'b0;
        total_cnt++; if (wr_en !== 1'b0 || wr_reg !== 5'd0 || wr_data !== 32'h55)
            $display("FAIL x0_write got %b/%0d/%h want 0/0/55", wr_en, wr_reg, wr_data); else pass_cnt++;
        step();
        total_cnt++; if (retire_count !== exp_retire) $display("FAIL x0_retire got %0d want %0d", retire_count, exp_retire); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < REG_COUNT; r++) regfile[r] = 32'd0;
        mem_valid = 1'b1;
        for (int r = 1; r < REG_COUNT; r++) begin
            vals[r]  = $urandom;
            mem_reg  = 5'(r);
            mem_data = vals[r];
            #1;
            total_cnt++; if (mem_ready !== 1'b1) $display("FAIL b2b_ready r%0d got %b want 1", r, mem_ready); else pass_cnt++;
            step();
            total_cnt++; if (wr_en !== 1'b1 || wr_reg !== 5'(r))
                $display("FAIL b2b_port r%0d got %b/%0d want 1/%0d", r, wr_en, wr_reg, r); else pass_cnt++;
        end
        mem_valid = 1'b0;
        step();
        step();
        for (int r = 1; r < REG_COUNT; r++) begin
            total_cnt++; if (regfile[r] !== vals[r]) $display("FAIL b2b_readback r%0d got %h want %h", r, regfile[r], vals[r]); else pass_cnt++;
        end
        exp_retire = exp_retire + 32'd31;
        total_cnt++; if (retire_count !== exp_retire) $display("FAIL b2b_retire got %0d want %0d", retire_count, exp_retire); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_mid_reset();
        test_single_alu();
        test_priority();
        test_starvation();
        test_x0();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after 200000 time units");
        $fatal(1, "watchdog");
    end

endmodule
